// File: rtl/fft_bar_writer_pkg.sv
// Shared definitions for the spectrum frame buffer (writer and display path).
// Holds the raster geometry, the frame-buffer address/colour widths, the colour
// code constants, the writer FSM state type and the level-to-colour helper.
package fft_bar_writer_pkg;

  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int FB_DEPTH   = 307200;
  localparam int FB_ADDR_W  = 19;
  localparam int COLOR_W    = 3;
  localparam int LEVEL_W    = 9;

  localparam logic [COLOR_W-1:0] COLOR_BLACK = 3'd0;
  localparam logic [COLOR_W-1:0] COLOR_1     = 3'd1;
  localparam logic [COLOR_W-1:0] COLOR_2     = 3'd2;
  localparam logic [COLOR_W-1:0] COLOR_3     = 3'd3;
  localparam logic [COLOR_W-1:0] COLOR_4     = 3'd4;
  localparam logic [COLOR_W-1:0] COLOR_5     = 3'd5;
  localparam logic [COLOR_W-1:0] COLOR_6     = 3'd6;
  localparam logic [COLOR_W-1:0] COLOR_7     = 3'd7;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_PAINT = 2'd2
  } state_t;

  // Colour of a lit pixel: one palette step per 64 lines of height, saturating at 7.
  function automatic logic [COLOR_W-1:0] level_to_code(input logic [LEVEL_W-1:0] level);
    logic [2:0] band;
    band = 3'(level >> 6);
    if (band >= 3'd6) begin
      return COLOR_7;
    end else begin
      return band + 3'd1;
    end
  endfunction

endpackage

// File: rtl/fft_bar_writer_if.sv
// Bus bundle of the bar writer.
//   mag_valid/mag_ready/mag_data/mag_last : height beat stream into the writer
//   wr_en/wr_addr/wr_data                 : frame-buffer write port out of the writer
// Modport slave is the writer; modport master is the producer / buffer side.
interface fft_bar_writer_if
  import fft_bar_writer_pkg::*;
#(
  parameter int HEIGHT_W = 9
);
  logic                 mag_valid;
  logic                 mag_ready;
  logic [HEIGHT_W-1:0]  mag_data;
  logic                 mag_last;
  logic                 wr_en;
  logic [FB_ADDR_W-1:0] wr_addr;
  logic [COLOR_W-1:0]   wr_data;

  modport slave (
    input  mag_valid, mag_data, mag_last,
    output mag_ready, wr_en, wr_addr, wr_data
  );

  modport master (
    output mag_valid, mag_data, mag_last,
    input  mag_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/bar_height_regfile.sv
// Bar height store: NUM_BARS registers of HEIGHT_W bits.
//   clk, rst_n       : clock, asynchronous active-low clear of every entry
//   i_we/i_waddr/i_wdata : synchronous single-entry write
//   i_fill/i_fill_from   : zero every entry with index >= i_fill_from (same cycle
//                          as a write to i_fill_from-1, used on a short frame)
//   i_raddr/o_rdata      : combinational read
module bar_height_regfile #(
  parameter int NUM_BARS = 64,
  parameter int HEIGHT_W = 9,
  parameter int IDX_W    = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_we,
  input  logic [IDX_W-1:0]    i_waddr,
  input  logic [HEIGHT_W-1:0] i_wdata,
  input  logic                i_fill,
  input  logic [IDX_W:0]      i_fill_from,
  input  logic [IDX_W-1:0]    i_raddr,
  output logic [HEIGHT_W-1:0] o_rdata
);

  logic [HEIGHT_W-1:0] r_height [NUM_BARS];

  // Height storage: explicit write wins, otherwise bulk zero-fill of the tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_BARS; k++) begin
        r_height[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_BARS; k++) begin
        if (i_we && (i_waddr == IDX_W'(k))) begin
          r_height[k] <= i_wdata;
        end else if (i_fill && ((IDX_W+1)'(k) >= i_fill_from)) begin
          r_height[k] <= '0;
        end else begin
          r_height[k] <= r_height[k];
        end
      end
    end
  end

  assign o_rdata = r_height[i_raddr];

endmodule

// File: rtl/fft_bar_writer.sv
// Writer side of the bar-graph frame buffer.
// Loads one frame of bar heights from the stream, then rasterises the whole
// buffer (one write per cycle, address x + y*H_ACTIVE) as vertical bars.
//   video_clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)        : height stream in, frame-buffer write port out
//   frame_ready        : sticky, a complete frame has been written
//   frame_done         : one-cycle pulse the cycle after the last write
//   busy               : high while painting
module fft_bar_writer #(
  parameter int NUM_BARS  = 64,
  parameter int BAR_WIDTH = 10,
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int HEIGHT_W  = 9
) (
  input  logic            video_clk,
  input  logic            reset_n,
  fft_bar_writer_if.slave bus,
  output logic            frame_ready,
  output logic            frame_done,
  output logic            busy
);
  import fft_bar_writer_pkg::*;

  localparam int IDX_W = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
  localparam int CNT_W = IDX_W + 1;
  localparam int X_W   = $clog2(H_ACTIVE);
  localparam int Y_W   = $clog2(V_ACTIVE);
  localparam int PX_W  = (BAR_WIDTH > 1) ? $clog2(BAR_WIDTH) : 1;
  localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  state_t               r_state;
  state_t               w_next_state;
  logic                 r_mag_ready;
  logic                 r_busy;
  logic [CNT_W-1:0]     r_bar_cnt;
  logic [X_W-1:0]       r_x;
  logic [Y_W-1:0]       r_y;
  logic [PX_W-1:0]      r_px_in_bar;
  logic [IDX_W-1:0]     r_bar_idx;
  logic [FB_ADDR_W-1:0] r_addr;
  logic                 r_wr_en;
  logic [FB_ADDR_W-1:0] r_wr_addr;
  logic [COLOR_W-1:0]   r_wr_data;
  logic                 r_frame_done;
  logic                 r_frame_ready;

  logic                 w_hs;
  logic                 w_store;
  logic                 w_fill;
  logic                 w_last_px;
  logic                 w_last_write;
  logic [CNT_W-1:0]     w_fill_from;
  logic [HEIGHT_W-1:0]  w_clamped;
  logic [HEIGHT_W-1:0]  w_rd_height;
  logic [HEIGHT_W-1:0]  w_level;
  logic [COLOR_W-1:0]   w_code;

  assign w_hs         = bus.mag_valid & r_mag_ready;
  assign w_last_px    = (r_x == X_W'(H_ACTIVE - 1)) && (r_y == Y_W'(V_ACTIVE - 1));
  assign w_last_write = r_wr_en && (r_wr_addr == LAST_ADDR);
  assign w_fill_from  = r_bar_cnt + CNT_W'(1);

  bar_height_regfile #(
    .NUM_BARS (NUM_BARS),
    .HEIGHT_W (HEIGHT_W),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .clk         (video_clk),
    .rst_n       (reset_n),
    .i_we        (w_store),
    .i_waddr     (r_bar_cnt[IDX_W-1:0]),
    .i_wdata     (w_clamped),
    .i_fill      (w_fill),
    .i_fill_from (w_fill_from),
    .i_raddr     (r_bar_idx),
    .o_rdata     (w_rd_height)
  );

  // Height clamp and per-pixel colour; level counts up from the bottom line.
  always_comb begin
    w_clamped = bus.mag_data;
    w_code    = COLOR_BLACK;
    if (bus.mag_data > HEIGHT_W'(V_ACTIVE)) begin
      w_clamped = HEIGHT_W'(V_ACTIVE);
    end else begin
      w_clamped = bus.mag_data;
    end
    w_level = HEIGHT_W'(V_ACTIVE - 1) - HEIGHT_W'(r_y);
    if (w_level < w_rd_height) begin
      w_code = level_to_code(LEVEL_W'(w_level));
    end else begin
      w_code = COLOR_BLACK;
    end
  end

  // Next-state logic plus store/zero-fill strobes for the height registers.
  always_comb begin
    w_next_state = r_state;
    w_store      = 1'b0;
    w_fill       = 1'b0;
    case (r_state)
      ST_LOAD: begin
        if (w_hs) begin
          w_store = 1'b1;
          if (bus.mag_last) begin
            w_fill       = 1'b1;
            w_next_state = ST_PAINT;
          end else if (r_bar_cnt == CNT_W'(NUM_BARS - 1)) begin
            w_next_state = ST_DRAIN;
          end else begin
            w_next_state = ST_LOAD;
          end
        end else begin
          w_next_state = ST_LOAD;
        end
      end
      ST_DRAIN: begin
        if (w_hs && bus.mag_last) begin
          w_next_state = ST_PAINT;
        end else begin
          w_next_state = ST_DRAIN;
        end
      end
      ST_PAINT: begin
        if (w_last_px) begin
          w_next_state = ST_LOAD;
        end else begin
          w_next_state = ST_PAINT;
        end
      end
      default: begin
        w_next_state = ST_LOAD;
      end
    endcase
  end

  // State register; ready/busy are registered copies decoded from the next state.
  always_ff @(posedge video_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_LOAD;
      r_mag_ready <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_mag_ready <= (w_next_state != ST_PAINT);
      r_busy      <= (w_next_state == ST_PAINT);
    end
  end

  // Count accepted bars while loading; restart at the end of each paint.
  always_ff @(posedge video_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bar_cnt <= '0;
    end else if ((r_state == ST_PAINT) && w_last_px) begin
      r_bar_cnt <= '0;
    end else if ((r_state == ST_LOAD) && w_hs) begin
      r_bar_cnt <= r_bar_cnt + CNT_W'(1);
    end else begin
      r_bar_cnt <= r_bar_cnt;
    end
  end

  // Raster walk: column/bar tracking by counting and address by accumulation,
  // so neither a divider nor a multiplier is needed.
  always_ff @(posedge video_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x         <= '0;
      r_y         <= '0;
      r_px_in_bar <= '0;
      r_bar_idx   <= '0;
      r_addr      <= '0;
    end else if (r_state == ST_PAINT) begin
      if (w_last_px) begin
        r_x         <= '0;
        r_y         <= '0;
        r_px_in_bar <= '0;
        r_bar_idx   <= '0;
        r_addr      <= '0;
      end else if (r_x == X_W'(H_ACTIVE - 1)) begin
        r_x         <= '0;
        r_y         <= r_y + Y_W'(1);
        r_px_in_bar <= '0;
        r_bar_idx   <= '0;
        r_addr      <= r_addr + FB_ADDR_W'(1);
      end else begin
        r_x    <= r_x + X_W'(1);
        r_addr <= r_addr + FB_ADDR_W'(1);
        if (r_px_in_bar == PX_W'(BAR_WIDTH - 1)) begin
          r_px_in_bar <= '0;
          r_bar_idx   <= r_bar_idx + IDX_W'(1);
        end else begin
          r_px_in_bar <= r_px_in_bar + PX_W'(1);
          r_bar_idx   <= r_bar_idx;
        end
      end
    end else begin
      r_x         <= '0;
      r_y         <= '0;
      r_px_in_bar <= '0;
      r_bar_idx   <= '0;
      r_addr      <= '0;
    end
  end

  // One-stage write pipeline and end-of-frame flags (taken off the last write).
  always_ff @(posedge video_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= COLOR_BLACK;
      r_frame_done  <= 1'b0;
      r_frame_ready <= 1'b0;
    end else begin
      r_wr_en       <= (r_state == ST_PAINT);
      r_wr_addr     <= (r_state == ST_PAINT) ? r_addr : '0;
      r_wr_data     <= (r_state == ST_PAINT) ? w_code : COLOR_BLACK;
      r_frame_done  <= w_last_write;
      r_frame_ready <= r_frame_ready | w_last_write;
    end
  end

  assign bus.mag_ready = r_mag_ready;
  assign bus.wr_en     = r_wr_en;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign frame_ready   = r_frame_ready;
  assign frame_done    = r_frame_done;
  assign busy          = r_busy;

endmodule

// File: tb/tb_fft_bar_writer.sv
// Self-checking bench for fft_bar_writer on a reduced raster (16 x 448, 8 bars
// of 2 columns) so each paint is short while every colour band is reachable.
// Expected pixels come from a model that evaluates the bar rules per address.
module tb_fft_bar_writer;
  import fft_bar_writer_pkg::*;

  localparam int NB   = 8;
  localparam int BW   = 2;
  localparam int HA   = 16;
  localparam int VA   = 448;
  localparam int HW   = 9;
  localparam int NPIX = HA * VA;

  typedef struct {
    int tid;
    int addr;
    int exp;
  } probe_t;

  logic video_clk = 1'b0;
  logic reset_n;
  logic frame_ready;
  logic frame_done;
  logic busy;

  int n_cmp = 0;
  int n_bad = 0;
  int n_pr  = 0;
  int ref_h [NB];
  logic [2:0] cap [NPIX];
  probe_t probes [$];

  fft_bar_writer_if #(.HEIGHT_W(HW)) bus ();

  fft_bar_writer #(
    .NUM_BARS (NB),
    .BAR_WIDTH(BW),
    .H_ACTIVE (HA),
    .V_ACTIVE (VA),
    .HEIGHT_W (HW)
  ) dut (
    .video_clk  (video_clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .frame_ready(frame_ready),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 video_clk = ~video_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference colour of one frame-buffer address from the current heights.
  function automatic int exp_code(input int addr);
    int x, y, bar, level, c;
    x     = addr % HA;
    y     = addr / HA;
    bar   = x / BW;
    level = (VA - 1) - y;
    c     = 0;
    if (level < ref_h[bar]) begin
      c = 1 + level / 64;
      if (c > 7) c = 7;
    end
    return c;
  endfunction

  function automatic void add_probe(input int t, input int a, input int e);
    probe_t p;
    p.tid  = t;
    p.addr = a;
    p.exp  = e;
    probes.push_back(p);
  endfunction

  // Sends a frame of beats; updates the reference heights from the load rules.
  task automatic send_frame(input int vals[$], input int last_idx, input int gap_max);
    int g;
    for (int i = 0; i < vals.size(); i++) begin
      if (i < NB) begin
        ref_h[i] = (vals[i] > VA) ? VA : vals[i];
        if (i == last_idx) begin
          for (int j = i + 1; j < NB; j++) ref_h[j] = 0;
        end
      end
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      for (int k = 0; k < g; k++) begin
        @(negedge video_clk);
        bus.mag_valid = 1'b0;
        bus.mag_data  = 9'($urandom);
        bus.mag_last  = 1'b0;
      end
      @(negedge video_clk);
      bus.mag_valid = 1'b1;
      bus.mag_data  = 9'(vals[i]);
      bus.mag_last  = (i == last_idx);
      check("mag_ready_on_beat", bus.mag_ready, 1);
      @(posedge video_clk);
    end
    @(negedge video_clk);
    bus.mag_valid = 1'b0;
    bus.mag_last  = 1'b0;
    check("busy_after_last", busy, 1);
    check("ready_low_in_paint", bus.mag_ready, 0);
  endtask

  // Checks npix consecutive writes from address 0 against the model.
  task automatic paint_pixels(input int npix);
    int e;
    for (int i = 0; i < npix; i++) begin
      @(negedge video_clk);
      e = exp_code(i);
      cap[i] = bus.wr_data;
      n_cmp++;
      if (!(bus.wr_en === 1'b1 && bus.wr_addr === 19'(i) && bus.wr_data === 3'(e))) begin
        n_bad++;
        if (n_pr < 20) begin
          $display("FAIL pixel %0d: got en=%0b addr=%0d data=%0d expected en=1 addr=%0d data=%0d",
                   i, bus.wr_en, bus.wr_addr, bus.wr_data, i, e);
        end
        n_pr++;
      end
    end
  endtask

  task automatic paint_check(input int tid);
    paint_pixels(NPIX);
    @(negedge video_clk);
    check("frame_done_pulse", frame_done, 1);
    check("wr_en_after_frame", bus.wr_en, 0);
    check("frame_ready_after", frame_ready, 1);
    check("busy_after_frame", busy, 0);
    check("ready_after_frame", bus.mag_ready, 1);
    @(negedge video_clk);
    check("frame_done_single", frame_done, 0);
    foreach (probes[p]) begin
      if (probes[p].tid == tid) begin
        check($sformatf("probe_t%0d_addr%0d", tid, probes[p].addr), 32'(cap[probes[p].addr]),
              32'(probes[p].exp));
      end
    end
  endtask

  initial begin
    int q[$];

    // Hand-derived spot values for the directed frames.
    add_probe(1, 0, 7);      add_probe(1, 7167, 1);
    add_probe(1, 6128, 2);   add_probe(1, 6144, 1);
    add_probe(2, 7167, 1);   add_probe(2, 7152, 0);
    add_probe(2, 7154, 1);   add_probe(2, 7138, 0);
    add_probe(2, 7155, 1);
    add_probe(3, 5568, 2);   add_probe(3, 5552, 0);
    add_probe(3, 7154, 0);   add_probe(3, 7153, 1);
    add_probe(5, 10, 7);     add_probe(5, 7162, 1);

    for (int i = 0; i < NB; i++) ref_h[i] = 0;
    reset_n       = 1'b0;
    bus.mag_valid = 1'b0;
    bus.mag_data  = '0;
    bus.mag_last  = 1'b0;
    repeat (3) @(negedge video_clk);
    check("rst_mag_ready", bus.mag_ready, 1);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_data", bus.wr_data, 0);
    check("rst_frame_ready", frame_ready, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy", busy, 0);
    reset_n = 1'b1;
    repeat (5) @(negedge video_clk);
    check("idle_no_write", bus.wr_en, 0);
    check("idle_ready", bus.mag_ready, 1);

    // 1: all bars full height
    q = {};
    for (int i = 0; i < NB; i++) q.push_back(VA);
    send_frame(q, NB - 1, 0);
    check("frame_ready_before_first", frame_ready, 0);
    paint_check(1);

    // 2: bar k has height k
    q = {};
    for (int i = 0; i < NB; i++) q.push_back(i);
    send_frame(q, NB - 1, 1);
    paint_check(2);

    // 3: single beat, height 100
    q = {100};
    send_frame(q, 0, 0);
    paint_check(3);

    // 4: NB+6 beats, the extra ones drained
    q = {};
    for (int i = 0; i < NB + 6; i++) q.push_back(int'($urandom_range(511, 0)));
    send_frame(q, NB + 5, 3);
    paint_check(4);

    // 5: over-range height on bar 5
    q = {};
    for (int i = 0; i < NB; i++) q.push_back(int'($urandom_range(511, 0)));
    q[5] = 511;
    send_frame(q, NB - 1, 2);
    paint_check(5);

    // 6: reset in the middle of a paint
    q = {};
    for (int i = 0; i < NB; i++) q.push_back(int'($urandom_range(511, 0)));
    send_frame(q, NB - 1, 0);
    paint_pixels(1000);
    reset_n = 1'b0;
    #1;
    check("midrst_wr_en", bus.wr_en, 0);
    check("midrst_frame_ready", frame_ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", bus.mag_ready, 1);
    for (int i = 0; i < NB; i++) ref_h[i] = 0;
    repeat (3) begin
      @(negedge video_clk);
      check("rst_hold_wr_en", bus.wr_en, 0);
      check("rst_hold_frame_ready", frame_ready, 0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge video_clk);
      check("post_rst_no_write", bus.wr_en, 0);
      check("post_rst_ready", bus.mag_ready, 1);
    end
    check("post_rst_frame_ready", frame_ready, 0);

    // 7: fresh short frame after the abandoned one
    q = {};
    for (int i = 0; i < 3; i++) q.push_back(int'($urandom_range(511, 0)));
    send_frame(q, 2, 2);
    paint_check(7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_bar_writer.md
Name: fft_bar_writer

Overview:
Writer side of the 640x480 frame buffer that the VGA color-output stage reads.
- Accepts one spectrum frame of bar heights over a valid/ready stream.
- Paints the full buffer as vertical bars, one 3-bit color code per pixel at address x + y*640.
- Asserts `frame_ready` once a complete frame has been written, so the display path may start reading.

Parameters:
- NUM_BARS, 64: bars per frame. Must equal H_ACTIVE / BAR_WIDTH.
- BAR_WIDTH, 10: pixel columns per bar.
- H_ACTIVE, 640: active pixels per line.
- V_ACTIVE, 480: active lines.
- HEIGHT_W, 9: height field width.

Ports:
- video_clk  in  1  single clock, shared with the display path
- reset_n  in  1  asynchronous, active-low reset
- mag_valid  in  1  height beat valid
- mag_ready  out  1  writer accepts a beat this cycle
- mag_data  in  HEIGHT_W  bar height in pixels
- mag_last  in  1  final beat of a spectrum frame
- wr_en  out  1  frame-buffer write strobe
- wr_addr  out  19  frame-buffer address, x + y*640
- wr_data  out  3  color code; 0 = black, 1..7 = palette index
- frame_ready  out  1  sticky: at least one full frame has been written
- frame_done  out  1  one-cycle pulse at the end of each paint
- busy  out  1  high in PAINT

Behaviour:
Interface:
- One clock, `video_clk`. Reset `reset_n` is asynchronous and active-low.
- Reset values: all outputs 0, except `mag_ready` = 1 (FSM resets into LOAD). Counters and the height store clear to 0.

FSM: LOAD -> DRAIN -> PAINT -> LOAD.
- LOAD
  - `mag_ready` = 1.
  - Each handshake (`mag_valid` & `mag_ready`) stores min(`mag_data`, V_ACTIVE) into height[bar_cnt] and increments bar_cnt.
  - Handshake with `mag_last`=1: bars not yet written are set to 0, then go to PAINT.
  - NUM_BARS-th handshake without `mag_last`: go to DRAIN.
- DRAIN
  - `mag_ready` = 1. Beats are discarded.
  - Handshake with `mag_last`=1: go to PAINT.
- PAINT
  - `mag_ready` = 0, `busy` = 1.
  - Raster counters x (0..639) and y (0..479) plus an incremental address step once per cycle with no stalls.
  - Column tracking: px_in_bar counts 0..BAR_WIDTH-1 and bar_idx advances on its wrap. No divider.
  - The address is accumulated incrementally (+1 per pixel). No multiplier.
  - On the final pixel (x=639, y=479): go to LOAD, pulse `frame_done`, set `frame_ready`, clear bar_cnt.
- Latency: a 1-stage registered write pipeline.
  - `wr_en`, `wr_addr` and `wr_data` for pixel (x,y) appear one cycle after the counters hold (x,y).
  - Exactly 307200 `wr_en` cycles per paint, contiguous, addresses 0..307199 ascending.
  - `frame_done` coincides with the cycle after the last write.

Pixel rule:
- level = (V_ACTIVE-1) - y.
- Lit iff level < height[bar_idx].
- Lit code = min(7, 1 + (level >> 6)). Unlit code = 0.
- Height 0 gives an all-black column. Height 480 gives a full column.

Boundaries:
- `mag_valid` held low in LOAD: wait indefinitely.
- `mag_last` on the first beat: bar 0 keeps its height; bars 1..63 are 0.
- `mag_data` > 480 is clamped to 480.
- Reset mid-PAINT or mid-LOAD:
  - `wr_en` drops immediately and `frame_ready` clears.
  - The partial frame is abandoned; on release the FSM restarts in LOAD.
- No synchronisation with the reader. Tearing is accepted.

Decomposition:
- Shared package (shared with the display path):
  - H_ACTIVE, V_ACTIVE, FB_DEPTH=307200, FB_ADDR_W=19, COLOR_W=3.
  - Color-code constants COLOR_BLACK=0 .. COLOR_7=7.
  - FSM state enum {LOAD, DRAIN, PAINT}.
- Sub-module `bar_height_regfile`:
  - NUM_BARS x HEIGHT_W registers.
  - Synchronous write port, combinational read port.
  - Clear-on-reset, plus a bulk zero-fill of unwritten entries.
  - Everything else stays in the top module.

Test Plan:
1. Reset, then 64 beats all of height 480 with `mag_last` on beat 64. Expect:
   - 307200 consecutive writes, addr 0..307199.
   - wr_data at addr 0 = 7; at addr 307199 (level 0) = 1; at y=415 (level 64) = 2.
   - One `frame_done` pulse; `frame_ready` high afterwards.
2. Heights 0,1,2,…,63 with bar k of height k. Expect:
   - addr 639 + 479*640 (bar 63, level 0) = 1.
   - addr 479*640 (bar 0) = 0.
   - Column x=10 (bar 1) lit only at y=479.
3. Single beat, height 100, `mag_last`=1. Expect:
   - x 0..9 lit for y ≥ 380; all x ≥ 10 black.
   - A write at y=380 → code 2; at y=379 → 0.
4. 70 beats with `mag_last` on beat 70. Expect:
   - Beats 65..70 accepted but discarded (`mag_ready`=1 in DRAIN).
   - PAINT starts the cycle after beat 70.
5. `mag_data`=511 for bar 5. Painted identically to 480 (column fully lit).
6. Assert `reset_n`=0 at paint pixel 1000, hold 3 cycles, release. Expect:
   - `wr_en`=0 and `frame_ready`=0 while reset is held.
   - FSM in LOAD with `mag_ready`=1; no further writes until a new frame is loaded.
